des_decrypt_core: RTL

Iterative DES decryption engine. Computes one Feistel round per clock and reuses the team's S1..S8 substitution modules, the inverse direction of the encryption datapath built around them. Accepts a 64-bit ciphertext and 64-bit key through a valid/ready handshake. Returns the 64-bit plaintext through a valid/ready handshake after 16 round cycles.

---
 rtl/des_decrypt_core.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/des_decrypt_core.sv
// rtl/des_decrypt_core.sv - iterative DES decryption core, one Feistel round per clock
//
// Ports:
//   Clk, Reset        clock, asynchronous active-high reset
//   InValid/InReady   input handshake for CipherIn (64b) and KeyIn (64b incl. parity)
//   OutValid/OutReady output handshake for PlainOut (64b)
//   KeyParityErr      some key byte had even parity (PARITY_CHECK=1 only)
// Bit convention: DES bit 1 is vector bit 63 (MSB first).

// Substitution box. Indexed directly by the raw 6-bit chunk; the outer bits
// select the row and the inner four bits the column.
module des_sbox #(
  parameter int BOX = 1
) (
  input  logic [5:0] DataIn,
  output logic [3:0] DataOut
);
  // Rows of S1..S8, row 0 first, column 0 in the leftmost nibble.
  localparam logic [0:511][3:0] S_TBL = {
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };
  localparam logic [2:0] BOX_SEL = 3'(BOX - 1);

  logic [8:0] idx;
  assign idx     = {BOX_SEL, DataIn[5], DataIn[0], DataIn[4:1]};
  assign DataOut = S_TBL[idx];
endmodule

module des_decrypt_core #(
  parameter bit PARITY_CHECK = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [63:0] CipherIn,
  input  logic [63:0] KeyIn,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [63:0] PlainOut,
  output logic        KeyParityErr
);
  // Permutation tables: entry i names the 1-based source bit of output bit i+1.
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                               16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [4:0]  rnd_q, rnd_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] plain_q, plain_d;
  logic        perr_q, perr_d;

  logic [63:0] ip_out, fp_in, fp_out;
  logic [55:0] pc1_out, cd_rot;
  logic [27:0] c_rot, d_rot;
  logic [47:0] pc2_out, e_out, s_in;
  logic [31:0] s_out, p_out, r_new;
  logic [7:0]  byte_err;
  logic        par_err;

  // Fixed-wiring permutations.
  for (genvar i = 0; i < 64; i++) begin : g_ip
    assign ip_out[63-i] = CipherIn[64-IP_T[i]];
    assign fp_out[63-i] = fp_in[64-FP_T[i]];
  end
  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_out[55-i] = KeyIn[64-PC1_T[i]];
  end
  for (genvar i = 0; i < 48; i++) begin : g_e_pc2
    assign e_out[47-i]   = r_q[32-E_T[i]];
    assign pc2_out[47-i] = cd_rot[56-PC2_T[i]];
  end
  for (genvar i = 0; i < 32; i++) begin : g_p
    assign p_out[31-i] = s_out[32-P_T[i]];
  end

  // Decryption walks the key schedule backwards: right rotations, and none
  // before the first round because C16/D16 equal PC1(key).
  always_comb begin
    c_rot = c_q;
    d_rot = d_q;
    case (rnd_q)
      5'd1: ;
      5'd2, 5'd9, 5'd16: begin
        c_rot = {c_q[0], c_q[27:1]};
        d_rot = {d_q[0], d_q[27:1]};
      end
      default: begin
        c_rot = {c_q[1:0], c_q[27:2]};
        d_rot = {d_q[1:0], d_q[27:2]};
      end
    endcase
  end
  assign cd_rot = {c_rot, d_rot};

  assign s_in = e_out ^ pc2_out;
  for (genvar k = 0; k < 8; k++) begin : g_sbox
    des_sbox #(.BOX(k + 1)) u_sbox (
      .DataIn (s_in[47-6*k -: 6]),
      .DataOut(s_out[31-4*k -: 4])
    );
  end
  assign r_new = l_q ^ p_out;
  // Final swap: output is R16 || L16 where L16 = R15 (current r_q).
  assign fp_in = {r_new, r_q};

  for (genvar b = 0; b < 8; b++) begin : g_par
    assign byte_err[b] = ~^KeyIn[8*b +: 8];
  end
  assign par_err = PARITY_CHECK & (|byte_err);

  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    r_d         = r_q;
    c_d         = c_q;
    d_d         = d_q;
    rnd_d       = rnd_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    plain_d     = plain_q;
    perr_d      = perr_q;
    case (state_q)
      IDLE: begin
        if (InValid && in_ready_q) begin
          l_d        = ip_out[63:32];
          r_d        = ip_out[31:0];
          c_d        = pc1_out[55:28];
          d_d        = pc1_out[27:0];
          rnd_d      = 5'd1;
          perr_d     = par_err;
          in_ready_d = 1'b0;
          state_d    = ROUND;
        end
      end
      ROUND: begin
        l_d   = r_q;
        r_d   = r_new;
        c_d   = c_rot;
        d_d   = d_rot;
        rnd_d = rnd_q + 5'd1;
        if (rnd_q == 5'd16) begin
          plain_d     = fp_out;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (OutReady) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      rnd_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      plain_q     <= '0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_q         <= r_d;
      c_q         <= c_d;
      d_q         <= d_d;
      rnd_q       <= rnd_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      plain_q     <= plain_d;
      perr_q      <= perr_d;
    end
  end

  assign InReady      = in_ready_q;
  assign OutValid     = out_valid_q;
  assign PlainOut     = plain_q;
  assign KeyParityErr = perr_q;
endmodule
